// File: rtl/avl_mm_arbiter.sv
// Two-requester Avalon-MM arbiter in front of one shared slave.
// Round-robin on ties, a stall timeout, and a sticky timeout flag.
module avl_mm_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_waitrequest,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_waitrequest,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest,
  output logic [1:0]        grant,
  output logic              timeout_flag,
  input  logic              timeout_clear
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_M1 =
    (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LIM = CW'(TO_M1);
  localparam logic TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t            state;
  logic [1:0]        grant_q;
  logic              last_grant;
  logic [CW-1:0]     stall_cnt;
  logic              to_flag_q;

  logic              act0;
  logic              act1;
  logic              cmd_act;
  logic              cmd_rd;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              to_hit;

  assign act0 = s0_read | s0_write;
  assign act1 = s1_read | s1_write;

  // Route the owner's command downstream; write wins over read.
  always_comb begin
    cmd_act   = 1'b0;
    cmd_rd    = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    unique case (1'b1)
      (state == GRANT0): begin
        cmd_act   = act0;
        cmd_rd    = s0_read & ~s0_write;
        cmd_wr    = s0_write;
        cmd_addr  = s0_address;
        cmd_wdata = s0_writedata;
      end
      (state == GRANT1): begin
        cmd_act   = act1;
        cmd_rd    = s1_read & ~s1_write;
        cmd_wr    = s1_write;
        cmd_addr  = s1_address;
        cmd_wdata = s1_writedata;
      end
      default: ;
    endcase
  end

  // Abort the stalled command once the stall count would reach the limit.
  assign to_hit = TO_EN & (state != IDLE) & cmd_act
                & m_waitrequest & (stall_cnt == TO_LIM);

  assign m_read      = cmd_rd & ~to_hit;
  assign m_write     = cmd_wr & ~to_hit;
  assign m_address   = cmd_addr;
  assign m_writedata = cmd_wdata;

  assign s0_waitrequest = (state == GRANT0)
                        ? (m_waitrequest & ~to_hit) : 1'b1;
  assign s1_waitrequest = (state == GRANT1)
                        ? (m_waitrequest & ~to_hit) : 1'b1;
  assign s0_readdata = (state != GRANT0) ? '0
                     : (to_hit ? '1 : m_readdata);
  assign s1_readdata = (state != GRANT1) ? '0
                     : (to_hit ? '1 : m_readdata);

  assign grant        = grant_q;
  assign timeout_flag = to_flag_q;

  // Arbitration FSM with registered grant and per-grant stall counter.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      grant_q    <= 2'b00;
      last_grant <= 1'b1;
      stall_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (act0 && (!act1 || last_grant)) begin
            state     <= GRANT0;
            grant_q   <= 2'b01;
            stall_cnt <= '0;
          end else if (act1) begin
            state     <= GRANT1;
            grant_q   <= 2'b10;
            stall_cnt <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (!cmd_act || !m_waitrequest || to_hit) begin
            state      <= IDLE;
            grant_q    <= 2'b00;
            last_grant <= (state == GRANT1);
          end else begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  // Sticky timeout indication; a new timeout beats a clear.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      to_flag_q <= 1'b0;
    else if (to_hit)
      to_flag_q <= 1'b1;
    else if (timeout_clear)
      to_flag_q <= 1'b0;
  end

endmodule
